data_sram_responder: RTL and testbench

- Slave (responder) end of the data-side sram-like bus (req / addr_ok / data_ok) that the MEM stage drives.
- Accepts read/write requests and stores data in an internal word-addressed RAM.
- Returns in-order responses with configurable accept and response latency.
- Serves as the data-memory model for CPU-level simulation and as a template for the later AXI bridge slave port.

---
 rtl/data_sram_responder.sv | 135 +++++++++++++
 tb/tb_data_sram_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data-side sram-like bus responder with word RAM and in-order response FIFO
module data_sram_responder #(
  parameter int ADDR_W        = 12,
  parameter int RESP_DEPTH    = 2,
  parameter int ADDR_OK_DELAY = 0,
  parameter int DATA_OK_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int ACC_W  = (ADDR_OK_DELAY > 0) ? $clog2(ADDR_OK_DELAY + 1) : 1;
  localparam int HEAD_W = (DATA_OK_DELAY > 1) ? $clog2(DATA_OK_DELAY) : 1;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       ram_word;

  logic              fifo_wr_q   [RESP_DEPTH];
  logic [31:0]       fifo_data_q [RESP_DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [HEAD_W-1:0] head_cnt_q, head_cnt_d;

  logic full, head_valid, push, pop;
  logic unused_bits;

  // Size and the byte offset never affect the stored word; the master extracts lanes.
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign idx        = addr[ADDR_W+1:2];
  assign ram_word   = mem[idx];

  assign full       = (count_q == CNT_W'(RESP_DEPTH));
  assign head_valid = (count_q != '0);

  assign addr_ok = resetn & req & (acc_cnt_q == ACC_W'(ADDR_OK_DELAY)) & ~full;
  assign push    = addr_ok;

  assign data_ok = resetn & head_valid & (head_cnt_q == HEAD_W'(DATA_OK_DELAY - 1));
  assign pop     = data_ok;

  assign rdata = (data_ok && !fifo_wr_q[rptr_q]) ? fifo_data_q[rptr_q] : 32'h0;

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    head_cnt_d = head_cnt_q;

    // Saturate while stalled on a full FIFO so the request goes out as soon as a slot frees.
    if (!req || addr_ok) begin
      acc_cnt_d = '0;
    end else if (acc_cnt_q != ACC_W'(ADDR_OK_DELAY)) begin
      acc_cnt_d = acc_cnt_q + ACC_W'(1);
    end

    if (push) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop || !head_valid) begin
      head_cnt_d = '0;
    end else begin
      head_cnt_d = head_cnt_q + HEAD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_cnt_q  <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      head_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      head_cnt_q <= head_cnt_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[wptr_q]   <= wr;
      fifo_data_q[wptr_q] <= wr ? 32'h0 : ram_word;
    end
  end

  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - directed and randomized checks of data_sram_responder against a word-level model
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: default parameters.
  logic        req0, wr0, aok0, dok0;
  logic [1:0]  size0;
  logic [3:0]  wstrb0;
  logic [31:0] addr0, wdata0, rd0;

  // Instance 1: slow responses, DATA_OK_DELAY=3, RESP_DEPTH=2.
  logic        req1, wr1, aok1, dok1;
  logic [1:0]  size1;
  logic [3:0]  wstrb1;
  logic [31:0] addr1, wdata1, rd1;

  // Instance 2: delayed accept, ADDR_OK_DELAY=2.
  logic        req2, wr2, aok2, dok2;
  logic [1:0]  size2;
  logic [3:0]  wstrb2;
  logic [31:0] addr2, wdata2, rd2;

  data_sram_responder u_dut0 (
    .clk(clk), .resetn(resetn), .req(req0), .wr(wr0), .size(size0), .wstrb(wstrb0),
    .addr(addr0), .wdata(wdata0), .addr_ok(aok0), .data_ok(dok0), .rdata(rd0)
  );

  data_sram_responder #(.RESP_DEPTH(2), .DATA_OK_DELAY(3)) u_dut1 (
    .clk(clk), .resetn(resetn), .req(req1), .wr(wr1), .size(size1), .wstrb(wstrb1),
    .addr(addr1), .wdata(wdata1), .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
  );

  data_sram_responder #(.ADDR_OK_DELAY(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .req(req2), .wr(wr2), .size(size2), .wstrb(wstrb2),
    .addr(addr2), .wdata(wdata2), .addr_ok(aok2), .data_ok(dok2), .rdata(rd2)
  );

  // Reference for instance 0: word memory over indices 0..15 plus the single response due next cycle.
  logic [31:0] ref0 [16];
  logic        exp_dok0;
  logic [31:0] exp_rd0;
  logic [31:0] w1, w2, w3, w5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // With one-cycle responses the FIFO never fills: every req is accepted and answered next cycle.
  task automatic cyc0(input bit r, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    logic [31:0] sz;
    @(negedge clk);
    sz = $urandom;
    req0 = r; wr0 = w; addr0 = a; wstrb0 = s; wdata0 = d; size0 = sz[1:0];
    #1;
    chk("d0_addr_ok", aok0, r);
    chk("d0_data_ok", dok0, exp_dok0);
    chk("d0_rdata", rd0, exp_rd0);
    exp_dok0 = r;
    exp_rd0  = (r && !w) ? ref0[a[5:2]] : 32'h0;
    if (r && w) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) ref0[a[5:2]][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic cyc1(input string tag, input bit rn, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit ea, input bit ed, input logic [31:0] er);
    @(negedge clk);
    resetn = rn; req1 = r; wr1 = w; addr1 = a; wdata1 = d; wstrb1 = 4'hf;
    #1;
    chk({tag, "_addr_ok"}, aok1, ea);
    chk({tag, "_data_ok"}, dok1, ed);
    chk({tag, "_rdata"}, rd1, er);
  endtask

  task automatic cyc2(input string tag, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit ea, input bit ed, input logic [31:0] er);
    @(negedge clk);
    req2 = r; wr2 = w; addr2 = a; wdata2 = d; wstrb2 = 4'hf;
    #1;
    chk({tag, "_addr_ok"}, aok2, ea);
    chk({tag, "_data_ok"}, dok2, ed);
    chk({tag, "_rdata"}, rd2, er);
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rs;
    bit          rr, rw;

    resetn = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; size0 = 2'b10; wstrb0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b1; wr1 = 1'b0; size1 = 2'b10; wstrb1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;
    req2 = 1'b1; wr2 = 1'b0; size2 = 2'b10; wstrb2 = 4'h0; addr2 = 32'h0; wdata2 = 32'h0;
    exp_dok0 = 1'b0; exp_rd0 = 32'h0;
    w1 = $urandom; w2 = $urandom; w3 = $urandom; w5 = $urandom;

    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_addr_ok0", aok0, 1'b0);
      chk("rst_data_ok0", dok0, 1'b0);
      chk("rst_rdata0", rd0, 32'h0);
      chk("rst_addr_ok1", aok1, 1'b0);
      chk("rst_addr_ok2", aok2, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    resetn = 1'b1;

    // Defaults, byte write, write-then-read.
    cyc0(1, 1, 32'h10, 4'hf, 32'hDEADBEEF);
    cyc0(1, 0, 32'h10, 4'h0, 32'h0);
    cyc0(1, 1, 32'h11, 4'b0010, 32'hABABABAB);
    chk("t1_rdata", rd0, 32'hDEADBEEF);
    cyc0(1, 0, 32'h10, 4'h0, 32'h0);
    cyc0(1, 1, 32'h20, 4'hf, 32'h55AA55AA);
    chk("t2_rdata", rd0, 32'hDEADABEF);
    cyc0(1, 0, 32'h20, 4'h0, 32'h0);
    cyc0(0, 0, 32'h0, 4'h0, 32'h0);
    chk("t5_rdata", rd0, 32'h55AA55AA);

    for (int i = 0; i < 16; i++) begin
      cyc0(1, 1, 32'(i) << 2, 4'hf, $urandom);
    end

    // Random traffic; upper address bits vary to exercise aliasing onto indices 0..15.
    for (int n = 0; n < 300; n++) begin
      ra = $urandom; ra[13:6] = 8'h0;
      rd = $urandom; rs = 4'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      rw = 1'($urandom);
      cyc0(rr, rw, ra, rs, rd);
    end
    cyc0(0, 0, 32'h0, 4'h0, 32'h0);
    cyc0(0, 0, 32'h0, 4'h0, 32'h0);

    // Accept delay: held write lands on the third cycle; an abandoned write never lands.
    cyc2("t4_w0", 1, 1, 32'h14, w5, 0, 0, 32'h0);
    cyc2("t4_w1", 1, 1, 32'h14, w5, 0, 0, 32'h0);
    cyc2("t4_w2", 1, 1, 32'h14, w5, 1, 0, 32'h0);
    cyc2("t4_w3", 0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    cyc2("t4_x0", 1, 1, 32'h14, ~w5, 0, 0, 32'h0);
    cyc2("t4_x1", 1, 1, 32'h14, ~w5, 0, 0, 32'h0);
    cyc2("t4_x2", 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc2("t4_r0", 1, 0, 32'h14, 32'h0, 0, 0, 32'h0);
    cyc2("t4_r1", 1, 0, 32'h14, 32'h0, 0, 0, 32'h0);
    cyc2("t4_r2", 1, 0, 32'h14, 32'h0, 1, 0, 32'h0);
    cyc2("t4_r3", 0, 0, 32'h0, 32'h0, 0, 1, w5);

    // Preload instance 1: each write answered three cycles after its handshake.
    cyc1("p1_w", 1, 1, 1, 32'h4, w1, 1, 0, 32'h0);
    cyc1("p1_a", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("p1_b", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("p1_d", 1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    cyc1("p2_w", 1, 1, 1, 32'h8, w2, 1, 0, 32'h0);
    cyc1("p2_a", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("p2_b", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("p2_d", 1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    cyc1("p3_w", 1, 1, 1, 32'hC, w3, 1, 0, 32'h0);
    cyc1("p3_a", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("p3_b", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("p3_d", 1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0);

    // Fill/stall with req held continuously.
    cyc1("t3_T0", 1, 1, 0, 32'h4, 32'h0, 1, 0, 32'h0);
    cyc1("t3_T1", 1, 1, 0, 32'h8, 32'h0, 1, 0, 32'h0);
    cyc1("t3_T2", 1, 1, 0, 32'hC, 32'h0, 0, 0, 32'h0);
    cyc1("t3_T3", 1, 1, 0, 32'hC, 32'h0, 0, 1, w1);
    cyc1("t3_T4", 1, 1, 0, 32'hC, 32'h0, 1, 0, 32'h0);
    cyc1("t3_T5", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("t3_T6", 1, 0, 0, 32'h0, 32'h0, 0, 1, w2);
    cyc1("t3_T7", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("t3_T8", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("t3_T9", 1, 0, 0, 32'h0, 32'h0, 0, 1, w3);
    cyc1("t3_T10", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Reset mid-op: the in-flight read is dropped, RAM survives.
    cyc1("t6_T0", 1, 1, 0, 32'h4, 32'h0, 1, 0, 32'h0);
    cyc1("t6_T1", 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("t6_T2", 1, 1, 0, 32'h8, 32'h0, 1, 0, 32'h0);
    cyc1("t6_T3", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("t6_T4", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc1("t6_T5", 1, 0, 0, 32'h0, 32'h0, 0, 1, w2);
    cyc1("t6_T6", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
